// File: rtl/vec_player_capture.sv
// -----------------------------------------------------------------------------
// vec_player_capture
// Stimulus/response engine for combinational benches. It replays stored vectors
// (or LFSR-random vectors), waits a settle window and captures the DUT response.
// Each captured word is streamed out over valid/ready and folded into a MISR.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   ld_en/ld_addr/ld_data   vector memory write port (ignored while busy)
//   start, abort            begin run / terminate run (abort wins)
//   mode, num_vec, seed     run configuration, sampled on start
//   dut_in, dut_out         registered vector to the DUT / DUT response
//   cap_valid/cap_data/
//   cap_ready               captured response stream
//   busy, done, vec_cnt     run status, vectors accepted downstream
//   signature               MISR signature of accepted words
// -----------------------------------------------------------------------------
module vec_player_capture #(
  parameter int unsigned      IN_W       = 32,
  parameter int unsigned      OUT_W      = 32,
  parameter int unsigned      DEPTH      = 8,
  parameter int unsigned      ADDR_W     = 3,
  parameter int unsigned      CNT_W      = 16,
  parameter int unsigned      SETTLE_CYC = 1,
  parameter logic [IN_W-1:0]  LFSR_POLY  = 32'h80200003,
  parameter logic [OUT_W-1:0] MISR_POLY  = 32'h04C11DB7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [IN_W-1:0]   ld_data,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic [IN_W-1:0]   seed,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              cap_valid,
  output logic [OUT_W-1:0]  cap_data,
  input  logic              cap_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  vec_cnt,
  output logic [OUT_W-1:0]  signature
);

  localparam int unsigned      SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Fibonacci LFSR step: shift left, XOR of tapped bits enters at bit 0.
  function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] cur);
    lfsr_step = {cur[IN_W-2:0], ^(cur & LFSR_POLY)};
  endfunction

  // MISR step: Galois shift with polynomial feedback, then fold in the new word.
  function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] sig,
                                                 input logic [OUT_W-1:0] word);
    misr_step = {sig[OUT_W-2:0], 1'b0}
              ^ (sig[OUT_W-1] ? MISR_POLY : {OUT_W{1'b0}})
              ^ word;
  endfunction

  state_t             state_r, state_nxt_s;
  logic [IN_W-1:0]    mem_r [DEPTH];
  logic               mode_r;
  logic [CNT_W-1:0]   num_vec_r;
  logic [ADDR_W-1:0]  idx_r;
  logic [SET_W-1:0]   settle_cnt_r;
  logic [IN_W-1:0]    lfsr_r;
  logic [IN_W-1:0]    dut_in_r;
  logic               cap_valid_r;
  logic [OUT_W-1:0]   cap_data_r;
  logic               busy_r;
  logic               done_r;
  logic [CNT_W-1:0]   vec_cnt_r;
  logic [OUT_W-1:0]   sig_r;

  logic               go_s;          // accepted start
  logic               settle_end_s;  // last settle cycle: capture now
  logic               hs_s;          // downstream handshake completes
  logic               last_s;        // handshake of the final vector
  logic [CNT_W-1:0]   vec_cnt_inc_s;

  assign vec_cnt_inc_s = vec_cnt_r + CNT_ONE;

  // Vector memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ld_en && !busy_r) begin
      mem_r[ld_addr] <= ld_data;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state and control strobes; abort overrides everything else.
  always_comb begin
    state_nxt_s  = state_r;
    go_s         = 1'b0;
    settle_end_s = 1'b0;
    hs_s         = 1'b0;
    last_s       = 1'b0;
    if (abort) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            go_s        = 1'b1;
            state_nxt_s = (num_vec == {CNT_W{1'b0}}) ? S_DONE : S_APPLY;
          end else begin
            state_nxt_s = state_r;
          end
        end
        S_APPLY: begin
          state_nxt_s = S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt_r == SET_LAST) begin
            settle_end_s = 1'b1;
            state_nxt_s  = S_CAPTURE;
          end else begin
            state_nxt_s = S_SETTLE;
          end
        end
        S_CAPTURE: begin
          if (cap_valid_r && cap_ready) begin
            hs_s = 1'b1;
            if (vec_cnt_inc_s == num_vec_r) begin
              last_s      = 1'b1;
              state_nxt_s = S_DONE;
            end else begin
              state_nxt_s = S_APPLY;
            end
          end else begin
            state_nxt_s = S_CAPTURE;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase
    end
  end

  // Datapath and status registers driven by the FSM strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r       <= 1'b0;
      num_vec_r    <= {CNT_W{1'b0}};
      idx_r        <= {ADDR_W{1'b0}};
      settle_cnt_r <= {SET_W{1'b0}};
      lfsr_r       <= {IN_W{1'b1}};
      dut_in_r     <= {IN_W{1'b0}};
      cap_valid_r  <= 1'b0;
      cap_data_r   <= {OUT_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      vec_cnt_r    <= {CNT_W{1'b0}};
      sig_r        <= {OUT_W{1'b0}};
    end else if (abort) begin
      // Signature, count and last vector stay visible after an abort.
      cap_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      if (go_s) begin
        mode_r    <= mode;
        num_vec_r <= num_vec;
        idx_r     <= {ADDR_W{1'b0}};
        vec_cnt_r <= {CNT_W{1'b0}};
        sig_r     <= {OUT_W{1'b0}};
        // An all-zero seed would lock the LFSR, so substitute all-ones.
        lfsr_r    <= (seed == {IN_W{1'b0}}) ? {IN_W{1'b1}} : seed;
        busy_r    <= (num_vec != {CNT_W{1'b0}});
        done_r    <= (num_vec == {CNT_W{1'b0}});
      end
      if (state_r == S_APPLY) begin
        dut_in_r     <= mode_r ? lfsr_r : mem_r[idx_r];
        settle_cnt_r <= {SET_W{1'b0}};
      end
      if (state_r == S_SETTLE) begin
        if (settle_end_s) begin
          cap_data_r  <= dut_out;
          cap_valid_r <= 1'b1;
        end else begin
          settle_cnt_r <= settle_cnt_r + SET_ONE;
        end
      end
      if (hs_s) begin
        cap_valid_r <= 1'b0;
        vec_cnt_r   <= vec_cnt_inc_s;
        lfsr_r      <= lfsr_step(lfsr_r);
        sig_r       <= misr_step(sig_r, cap_data_r);
        if (last_s) begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end else begin
          // Address wraps naturally when num_vec exceeds DEPTH.
          idx_r <= idx_r + ADDR_ONE;
        end
      end
    end
  end

  assign dut_in    = dut_in_r;
  assign cap_valid = cap_valid_r;
  assign cap_data  = cap_data_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign vec_cnt   = vec_cnt_r;
  assign signature = sig_r;

endmodule
